// File: rtl/slot_pkg.sv
// Shared slot-machine definitions: reel count, digit range,
// digit type and controller state encoding.
package slot_pkg;

    localparam int NUM_REELS = 4;
    localparam int MAX_DIGIT = 9;
    localparam int DIGIT_W   = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPIN  = 2'd1,
        SCORE = 2'd2
    } state_t;

endpackage

// File: rtl/reel_counter.sv
// One reel: a tick divider of DIV and a 0..9 digit.
// Ports: clk, rst (sync, active-high), tick, freeze, digit.
module reel_counter #(
    parameter int DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       freeze,
    output logic [3:0] digit
);

    import slot_pkg::*;

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam digit_t DIGIT_LAST = digit_t'(MAX_DIGIT);

    logic [CW-1:0] div_cnt;

    // The divider only moves while the reel is live, so a frozen reel
    // resumes with the same phase on the next spin.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            digit   <= '0;
        end else if (tick && !freeze) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                if (digit == DIGIT_LAST)
                    digit <= '0;
                else
                    digit <= digit + digit_t'(1);
            end else begin
                div_cnt <= div_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/reel_spin_ctrl.sv
// Spin/stop sequencer for four reels; pulses to_score when all landed.
// Ports: clk, rst, spin_tick, btn_spin, is_broke -> num0..3, stop, to_score, busy.
module reel_spin_ctrl #(
    parameter int NUM_REELS       = 4,
    parameter int AUTO_STOP_TICKS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spin_tick,
    input  logic       btn_spin,
    input  logic       is_broke,
    output logic [3:0] num0,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic [3:0] stop,
    output logic       to_score,
    output logic       busy
);

    import slot_pkg::*;

    localparam logic AUTO_EN = (AUTO_STOP_TICKS != 0);
    localparam logic [15:0] AUTO_LAST = 16'(AUTO_STOP_TICKS - 1);
    localparam logic [1:0] LAST_IDX = 2'(NUM_REELS - 1);

    state_t      state;
    logic [1:0]  idx;
    logic [15:0] auto_cnt;
    logic        btn_q;

    logic        press;
    logic        in_spin;
    logic        auto_fire;
    logic        stop_now;
    logic [3:0]  stop_mask;
    logic [3:0]  freeze;
    logic [3:0]  digits [NUM_REELS];

    assign press     = btn_spin & ~btn_q;
    assign in_spin   = (state == SPIN);
    assign auto_fire = AUTO_EN && in_spin && spin_tick
                       && (auto_cnt == AUTO_LAST);
    // A press and an auto-stop in the same cycle merge into one stop.
    assign stop_now  = in_spin && (press || auto_fire);
    assign stop_mask = stop_now ? (4'b0001 << idx) : 4'b0000;
    // The reel being stopped this cycle must not take a tick.
    assign freeze    = stop | stop_mask;

    for (genvar i = 0; i < NUM_REELS; i++) begin : g_reel
        reel_counter #(
            .DIV (i + 1)
        ) u_reel (
            .clk    (clk),
            .rst    (rst),
            .tick   (spin_tick),
            .freeze (freeze[i]),
            .digit  (digits[i])
        );
    end

    assign num0 = digits[0];
    assign num1 = digits[1];
    assign num2 = digits[2];
    assign num3 = digits[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            stop     <= 4'b1111;
            idx      <= '0;
            auto_cnt <= '0;
            btn_q    <= 1'b0;
            to_score <= 1'b0;
            busy     <= 1'b0;
        end else begin
            btn_q    <= btn_spin;
            to_score <= 1'b0;
            case (state)
                IDLE: begin
                    if (press && !is_broke) begin
                        stop     <= 4'b0000;
                        idx      <= '0;
                        auto_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= SPIN;
                    end
                end
                SPIN: begin
                    if (stop_now) begin
                        stop     <= stop | stop_mask;
                        auto_cnt <= '0;
                        idx      <= idx + 2'd1;
                        if (idx == LAST_IDX) begin
                            to_score <= 1'b1;
                            state    <= SCORE;
                        end
                    end else if (spin_tick && AUTO_EN) begin
                        auto_cnt <= auto_cnt + 16'd1;
                    end
                end
                SCORE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
